// File: rtl/sorter_pkg.sv
// Shared constants, state encoding and load-strobe encodings for sorted_pair_loader.
package sorter_pkg;

   localparam int N_LIST = 4;

   typedef enum logic [1:0] {
      FILL_B = 2'd0,
      LOAD_B = 2'd1,
      FILL_A = 2'd2,
      LOAD_A = 2'd3
   } state_t;

   localparam logic [1:0] LOAD_NONE  = 2'b00;
   localparam logic [1:0] LOAD_BHALF = 2'b01;
   localparam logic [1:0] LOAD_AHALF = 2'b10;

   function automatic logic is_fill(input state_t s);
      return (s == FILL_B) || (s == FILL_A);
   endfunction

endpackage

// File: rtl/sorted_pair_loader_insert_sort4.sv
// Combinational next-buffer for one insertion step into a 4-entry ascending list,
// with optional all-ones padding of the slots left empty after the insertion.
module insert_sort4
   import sorter_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [N_LIST-1:0][WIDTH-1:0] list_i,
   input  logic [2:0]                   cnt_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         ins_i,
   input  logic                         pad_i,
   output logic [N_LIST-1:0][WIDTH-1:0] list_o,
   output logic [2:0]                   cnt_o
);

   logic [2:0] pos;
   logic       found;

   // Strict greater-than places a new sample after any existing equals.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      pos   = cnt_i;
      found = 1'b0;
      for (int k = 0; k < N_LIST; k++) begin
         if (!found && (k < int'(cnt_i)) && (list_i[k] > data_i)) begin
            pos   = 3'(k);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_o  = cnt_i + {2'b00, ins_i};
      list_o = list_i;
      for (int k = 1; k < N_LIST; k++) begin
         if (ins_i && (k > int'(pos)) && (k <= int'(cnt_i))) list_o[k] = list_i[k-1];
      end
      for (int k = 0; k < N_LIST; k++) begin
         if (ins_i && (k == int'(pos))) list_o[k] = data_i;
         if (pad_i && (k >= int'(cnt_o))) list_o[k] = '1;
      end
   end

endmodule

// File: rtl/sorted_pair_loader.sv
// Serial sample collector: sorts groups of 4 and hands them to the 4+4 merge as B then A.
// Optional FLUSH_PAD_EN adds a flush input that pads a partial list with all-ones.
module sorted_pair_loader
   import sorter_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int N     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_data,
`ifdef FLUSH_PAD_EN
   input  logic                 flush,
`endif
   output logic                 in_ready,
   output logic [1:0]           load,
   output logic [8*WIDTH-1:0]   inba,
   output logic                 pair_done,
   output logic                 busy
);

   localparam int LIST_W = N * WIDTH;

   state_t                       state_q, state_d;
   logic [2:0]                   cnt_q, cnt_d;
   logic [N_LIST-1:0][WIDTH-1:0] list_q, list_d, list_ins;
   logic [2:0]                   cnt_ins;
   logic [8*WIDTH-1:0]           inba_q, inba_d;
   logic [1:0]                   load_q, load_d;
   logic                         pair_done_q, pair_done_d;
   logic                         xfer;
   logic                         pad;

   assign in_ready = is_fill(state_q);
   assign xfer     = in_valid && in_ready;

`ifdef FLUSH_PAD_EN
   assign pad = flush && is_fill(state_q) && (cnt_q != 3'd0);
`else
   assign pad = 1'b0;
`endif

   insert_sort4 #(.WIDTH(WIDTH)) u_insert (
      .list_i (list_q),
      .cnt_i  (cnt_q),
      .data_i (in_data),
      .ins_i  (xfer),
      .pad_i  (pad),
      .list_o (list_ins),
      .cnt_o  (cnt_ins)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      list_d      = list_q;
      inba_d      = inba_q;
      load_d      = LOAD_NONE;
      pair_done_d = 1'b0;
      case (state_q)
         FILL_B, FILL_A: begin
            if (xfer || pad) begin
               list_d = list_ins;
               cnt_d  = cnt_ins;
               if ((cnt_ins == 3'(N_LIST)) || pad) begin
                  if (state_q == FILL_B) begin
                     state_d               = LOAD_B;
                     inba_d[LIST_W-1:0]    = list_ins;
                     load_d                = LOAD_BHALF;
                  end else begin
                     state_d                  = LOAD_A;
                     inba_d[2*LIST_W-1:LIST_W] = list_ins;
                     load_d                   = LOAD_AHALF;
                     pair_done_d              = 1'b1;
                  end
               end
            end
         end
         LOAD_B: begin
            cnt_d   = 3'd0;
            list_d  = '0;
            state_d = FILL_A;
         end
         LOAD_A: begin
            cnt_d   = 3'd0;
            list_d  = '0;
            state_d = FILL_B;
         end
         default: state_d = FILL_B;
      endcase
   end

   // The sort buffer is reset as well: a partial list must never leak into the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q     <= FILL_B;
         cnt_q       <= 3'd0;
         list_q      <= '0;
         inba_q      <= '0;
         load_q      <= LOAD_NONE;
         pair_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         list_q      <= list_d;
         inba_q      <= inba_d;
         load_q      <= load_d;
         pair_done_q <= pair_done_d;
      end
   end

   assign load      = load_q;
   assign inba      = inba_q;
   assign pair_done = pair_done_q;
   assign busy      = (cnt_q != 3'd0) || !is_fill(state_q);

endmodule
